axi_rd_4_merger: RTL and testbench
==================================

Name: axi_rd_4_merger

Overview:
4-to-1 AXI read-channel merger: four upstream masters (a..d) share one downstream read slave. It is the counterpart of the 4-way read splitter, placed on the slave side of the NoC. AR requests are arbitrated round-robin and tagged with a 2-bit source index in the upper ID bits. R beats are routed back to the owning master by that tag.

Parameters:
EXTRAS, 8, width of the arextras sideband, passed through unchanged
IDWID, 4, upstream ID width; downstream ID width is IDWID+2
DWID, 64, read data width
MAXOUT, 16, max outstanding bursts downstream (used only with the optional feature); range 1..255

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
x_arid  in  IDWID  upstream AR ID, x in {a,b,c,d} (all x_ ports repeat per master)
x_araddr  in  32  upstream AR address
x_arlen  in  8  burst length-1
x_arextras  in  EXTRAS  sideband
x_arburst  in  2  burst type
x_arvalid  in  1  AR valid
x_arready  out  1  AR ready
x_rid  out  IDWID  R ID (tag stripped)
x_rdata  out  DWID  R data
x_rresp  out  2  R response
x_rlast  out  1  R last
x_rvalid  out  1  R valid
x_rready  in  1  R ready
arid  out  IDWID+2  downstream AR ID, {src[1:0], upstream arid}
araddr  out  32  downstream address, unmodified
arlen  out  8  downstream burst length
arextras  out  EXTRAS  downstream sideband
arburst  out  2  downstream burst type
arvalid  out  1  downstream AR valid
arready  in  1  downstream AR ready
rid  in  IDWID+2  downstream R ID
rdata  in  DWID  downstream R data
rresp  in  2  downstream R response
rlast  in  1  downstream R last
rvalid  in  1  downstream R valid
rready  out  1  downstream R ready

Behaviour:
- Reset (async, rst=1):
  - AR output register empty: arvalid=0, payload 0.
  - Round-robin pointer last_grant=3, so master a has first priority.
  - Outstanding count=0.
- AR output register: one entry.
  - load_en = !arvalid || arready.
  - It loads when load_en and any x_arvalid is high; otherwise it clears when arvalid && arready.
  - Latency: upstream handshake in cycle N gives arvalid=1 in cycle N+1.
  - Back-to-back issue is one per cycle while the downstream holds arready=1.
- Arbiter:
  - Priority order starts at (last_grant+1) mod 4 and ascends with wrap.
  - Grant goes to the first requester in that order.
  - x_arready = load_en && grant==x; it is combinational and independent of x_arvalid for non-granted masters, which always see 0.
  - last_grant updates only on an upstream handshake.
  - Granted payload is captured together with arid={grant[1:0], x_arid}.
- While arvalid=1 && arready=0, the register holds and all x_arready=0. Requests stay pending; nothing is dropped.
- R routing, combinational with no storage:
  - src = rid[IDWID+1:IDWID].
  - x_rvalid = rvalid && src==x.
  - rready = x_rready of the master selected by src.
  - x_rid = rid[IDWID-1:0]; rdata/rresp/rlast are broadcast to all four.
  - A non-selected master's x_rready has no effect.
- No reordering or interleave control: the downstream is responsible for AXI ordering per full ID. Distinct upstream masters get distinct tags, so no ID collision is possible.
- Reset mid-burst: all state is cleared and in-flight transactions are abandoned. Upstream masters must also be reset.

Optional Feature:
Macro AXI_RD_MERGER_OUTSTANDING_EN.
- When defined:
  - An 8-bit outstanding counter increments on each downstream AR handshake and decrements on each R handshake with rlast=1.
  - On a simultaneous increment and decrement the counter is unchanged.
  - When count + arvalid >= MAXOUT, load_en is forced to 0 and all x_arready=0.
  - The counter never wraps; reaching MAXOUT blocks further increments.
- When not defined: no counter exists, and the number of outstanding bursts is unlimited.

Test Plan:
1. Reset, then a_arvalid with araddr=0x1000, arid=3, arlen=7, downstream arready=1 -> a_arready=1 in cycle 0; cycle 1 shows arvalid=1, arid=6'h03, araddr=0x1000, arlen=7.
2. All four arvalid held high, arready=1, for 8 cycles -> grants a,b,c,d,a,b,c,d; downstream arid[5:4] = 0,1,2,3,0,1,2,3.
3. arready=0 for 5 cycles with b and c requesting -> arvalid stays 1 with a stable payload and all x_arready=0; after arready=1, the next grant follows round-robin order.
4. Downstream R burst rid=6'h25, 4 beats, rlast on the 4th -> only c_rvalid asserts, with c_rid=5; deasserting c_rready stalls rready while a/b/d_rready=1 are ignored.
5. With AXI_RD_MERGER_OUTSTANDING_EN and MAXOUT=2: issue 2 ARs and hold R -> third request blocked (x_arready=0); one rlast handshake -> the third issues the next cycle.
6. Assert rst while arvalid=1 mid-stall -> arvalid=0 immediately (async); after release, master a has priority.

Source files
------------

// File: rtl/axi_rd_4_merger.sv
// axi_rd_4_merger: 4-to-1 AXI read-channel merger.
// Four upstream masters (a..d) share one downstream read slave. AR requests
// are arbitrated round-robin into a single-entry output register and tagged
// with the 2-bit source index in the upper ID bits. R beats are routed back
// combinationally by that tag.
// Optional feature: define AXI_RD_MERGER_OUTSTANDING_EN to limit the number of
// outstanding downstream bursts to MAXOUT.
module axi_rd_4_merger #(
    parameter int EXTRAS = 8,
    parameter int IDWID  = 4,
    parameter int DWID   = 64,
    parameter int MAXOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    // master a
    input  logic [IDWID-1:0]    a_arid,
    input  logic [31:0]         a_araddr,
    input  logic [7:0]          a_arlen,
    input  logic [EXTRAS-1:0]   a_arextras,
    input  logic [1:0]          a_arburst,
    input  logic                a_arvalid,
    output logic                a_arready,
    output logic [IDWID-1:0]    a_rid,
    output logic [DWID-1:0]     a_rdata,
    output logic [1:0]          a_rresp,
    output logic                a_rlast,
    output logic                a_rvalid,
    input  logic                a_rready,
    // master b
    input  logic [IDWID-1:0]    b_arid,
    input  logic [31:0]         b_araddr,
    input  logic [7:0]          b_arlen,
    input  logic [EXTRAS-1:0]   b_arextras,
    input  logic [1:0]          b_arburst,
    input  logic                b_arvalid,
    output logic                b_arready,
    output logic [IDWID-1:0]    b_rid,
    output logic [DWID-1:0]     b_rdata,
    output logic [1:0]          b_rresp,
    output logic                b_rlast,
    output logic                b_rvalid,
    input  logic                b_rready,
    // master c
    input  logic [IDWID-1:0]    c_arid,
    input  logic [31:0]         c_araddr,
    input  logic [7:0]          c_arlen,
    input  logic [EXTRAS-1:0]   c_arextras,
    input  logic [1:0]          c_arburst,
    input  logic                c_arvalid,
    output logic                c_arready,
    output logic [IDWID-1:0]    c_rid,
    output logic [DWID-1:0]     c_rdata,
    output logic [1:0]          c_rresp,
    output logic                c_rlast,
    output logic                c_rvalid,
    input  logic                c_rready,
    // master d
    input  logic [IDWID-1:0]    d_arid,
    input  logic [31:0]         d_araddr,
    input  logic [7:0]          d_arlen,
    input  logic [EXTRAS-1:0]   d_arextras,
    input  logic [1:0]          d_arburst,
    input  logic                d_arvalid,
    output logic                d_arready,
    output logic [IDWID-1:0]    d_rid,
    output logic [DWID-1:0]     d_rdata,
    output logic [1:0]          d_rresp,
    output logic                d_rlast,
    output logic                d_rvalid,
    input  logic                d_rready,
    // downstream slave
    output logic [IDWID+1:0]    arid,
    output logic [31:0]         araddr,
    output logic [7:0]          arlen,
    output logic [EXTRAS-1:0]   arextras,
    output logic [1:0]          arburst,
    output logic                arvalid,
    input  logic                arready,
    input  logic [IDWID+1:0]    rid,
    input  logic [DWID-1:0]     rdata,
    input  logic [1:0]          rresp,
    input  logic                rlast,
    input  logic                rvalid,
    output logic                rready
);

    if (MAXOUT < 1 || MAXOUT > 255) begin : g_bad_maxout
        $error("axi_rd_4_merger: MAXOUT must be in 1..255");
    end

    logic [IDWID+1:0]  arid_q, arid_d;
    logic [31:0]       araddr_q, araddr_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [EXTRAS-1:0] arextras_q, arextras_d;
    logic [1:0]        arburst_q, arburst_d;
    logic              arvalid_q, arvalid_d;
    logic [1:0]        last_grant_q, last_grant_d;

    logic [3:0]        req;
    logic              any_req;
    logic [1:0]        grant;
    logic [1:0]        idx;
    logic              found;
    logic              load_en;
    logic              hs_up;

    logic [IDWID-1:0]  sel_id;
    logic [31:0]       sel_addr;
    logic [7:0]        sel_len;
    logic [EXTRAS-1:0] sel_extras;
    logic [1:0]        sel_burst;

    logic [1:0]        r_src;

    assign req     = {d_arvalid, c_arvalid, b_arvalid, a_arvalid};
    assign any_req = |req;

    // Round-robin: search starts one past the last granted master and wraps.
    always_comb begin
        grant = last_grant_q;
        found = 1'b0;
        idx   = last_grant_q;
        for (int i = 1; i <= 4; i++) begin
            idx = last_grant_q + 2'(i);
            if (!found && req[idx]) begin
                grant = idx;
                found = 1'b1;
            end
        end
    end

    // Payload mux for the granted master.
    always_comb begin
        sel_id     = a_arid;
        sel_addr   = a_araddr;
        sel_len    = a_arlen;
        sel_extras = a_arextras;
        sel_burst  = a_arburst;
        case (grant)
            2'd1: begin
                sel_id = b_arid; sel_addr = b_araddr; sel_len = b_arlen;
                sel_extras = b_arextras; sel_burst = b_arburst;
            end
            2'd2: begin
                sel_id = c_arid; sel_addr = c_araddr; sel_len = c_arlen;
                sel_extras = c_arextras; sel_burst = c_arburst;
            end
            2'd3: begin
                sel_id = d_arid; sel_addr = d_araddr; sel_len = d_arlen;
                sel_extras = d_arextras; sel_burst = d_arburst;
            end
            default: ;
        endcase
    end

`ifdef AXI_RD_MERGER_OUTSTANDING_EN
    logic [7:0] cnt_q, cnt_d;
    logic       cnt_inc, cnt_dec;
    logic       cnt_block;

    assign cnt_inc   = arvalid_q && arready;
    assign cnt_dec   = rvalid && rready && rlast;
    // The entry sitting in the output register counts as already outstanding.
    assign cnt_block = ({1'b0, cnt_q} + {8'd0, arvalid_q}) >= 9'(MAXOUT);
    assign load_en   = (!arvalid_q || arready) && !cnt_block;

    // Outstanding-burst counter; saturates at both ends rather than wrapping.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_inc && !cnt_dec && cnt_q != 8'hFF) begin
            cnt_d = cnt_q + 8'd1;
        end else if (cnt_dec && !cnt_inc && cnt_q != 8'h00) begin
            cnt_d = cnt_q - 8'd1;
        end
    end

    // Outstanding counter register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= 8'd0;
        end else begin
            cnt_q <= cnt_d;
        end
    end
`else
    assign load_en = !arvalid_q || arready;
`endif

    assign hs_up = load_en && any_req;

    assign a_arready = hs_up && (grant == 2'd0);
    assign b_arready = hs_up && (grant == 2'd1);
    assign c_arready = hs_up && (grant == 2'd2);
    assign d_arready = hs_up && (grant == 2'd3);

    // Output register next state: load on upstream handshake, else drain.
    always_comb begin
        arvalid_d    = arvalid_q;
        arid_d       = arid_q;
        araddr_d     = araddr_q;
        arlen_d      = arlen_q;
        arextras_d   = arextras_q;
        arburst_d    = arburst_q;
        last_grant_d = last_grant_q;
        if (hs_up) begin
            arvalid_d    = 1'b1;
            arid_d       = {grant, sel_id};
            araddr_d     = sel_addr;
            arlen_d      = sel_len;
            arextras_d   = sel_extras;
            arburst_d    = sel_burst;
            last_grant_d = grant;
        end else if (arvalid_q && arready) begin
            arvalid_d = 1'b0;
        end
    end

    // AR output register and round-robin pointer.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arvalid_q    <= 1'b0;
            arid_q       <= '0;
            araddr_q     <= '0;
            arlen_q      <= '0;
            arextras_q   <= '0;
            arburst_q    <= '0;
            last_grant_q <= 2'd3;
        end else begin
            arvalid_q    <= arvalid_d;
            arid_q       <= arid_d;
            araddr_q     <= araddr_d;
            arlen_q      <= arlen_d;
            arextras_q   <= arextras_d;
            arburst_q    <= arburst_d;
            last_grant_q <= last_grant_d;
        end
    end

    assign arvalid  = arvalid_q;
    assign arid     = arid_q;
    assign araddr   = araddr_q;
    assign arlen    = arlen_q;
    assign arextras = arextras_q;
    assign arburst  = arburst_q;

    assign r_src = rid[IDWID+1:IDWID];

    // R return path: steer valid by tag, take ready from the owning master only.
    always_comb begin
        rready = a_rready;
        case (r_src)
            2'd1:    rready = b_rready;
            2'd2:    rready = c_rready;
            2'd3:    rready = d_rready;
            default: rready = a_rready;
        endcase
    end

    assign a_rvalid = rvalid && (r_src == 2'd0);
    assign b_rvalid = rvalid && (r_src == 2'd1);
    assign c_rvalid = rvalid && (r_src == 2'd2);
    assign d_rvalid = rvalid && (r_src == 2'd3);

    assign a_rid = rid[IDWID-1:0];
    assign b_rid = rid[IDWID-1:0];
    assign c_rid = rid[IDWID-1:0];
    assign d_rid = rid[IDWID-1:0];

    assign a_rdata = rdata;
    assign b_rdata = rdata;
    assign c_rdata = rdata;
    assign d_rdata = rdata;

    assign a_rresp = rresp;
    assign b_rresp = rresp;
    assign c_rresp = rresp;
    assign d_rresp = rresp;

    assign a_rlast = rlast;
    assign b_rlast = rlast;
    assign c_rlast = rlast;
    assign d_rlast = rlast;

endmodule

// File: tb/tb_axi_rd_4_merger.sv
// Scoreboard bench for axi_rd_4_merger: randomized masters and downstream
// slave, expected AR order/handshakes and R routing from a queue-level model.
module tb_axi_rd_4_merger;
    localparam int EXTRAS = 8;
    localparam int IDWID  = 4;
    localparam int DWID   = 64;
    localparam int MAXOUT = 16;
    localparam int NCYC   = 3000;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [IDWID-1:0]  m_arid[4];
    logic [31:0]       m_araddr[4];
    logic [7:0]        m_arlen[4];
    logic [EXTRAS-1:0] m_arextras[4];
    logic [1:0]        m_arburst[4];
    logic              m_arvalid[4];
    logic              m_arready[4];
    logic [IDWID-1:0]  m_rid[4];
    logic [DWID-1:0]   m_rdata[4];
    logic [1:0]        m_rresp[4];
    logic              m_rlast[4];
    logic              m_rvalid[4];
    logic              m_rready[4];

    logic [IDWID+1:0]  arid;
    logic [31:0]       araddr;
    logic [7:0]        arlen;
    logic [EXTRAS-1:0] arextras;
    logic [1:0]        arburst;
    logic              arvalid;
    logic              arready;
    logic [IDWID+1:0]  rid;
    logic [DWID-1:0]   rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    axi_rd_4_merger #(.EXTRAS(EXTRAS), .IDWID(IDWID), .DWID(DWID), .MAXOUT(MAXOUT)) dut (
        .clk(clk), .rst(rst),
        .a_arid(m_arid[0]), .a_araddr(m_araddr[0]), .a_arlen(m_arlen[0]),
        .a_arextras(m_arextras[0]), .a_arburst(m_arburst[0]), .a_arvalid(m_arvalid[0]),
        .a_arready(m_arready[0]), .a_rid(m_rid[0]), .a_rdata(m_rdata[0]),
        .a_rresp(m_rresp[0]), .a_rlast(m_rlast[0]), .a_rvalid(m_rvalid[0]), .a_rready(m_rready[0]),
        .b_arid(m_arid[1]), .b_araddr(m_araddr[1]), .b_arlen(m_arlen[1]),
        .b_arextras(m_arextras[1]), .b_arburst(m_arburst[1]), .b_arvalid(m_arvalid[1]),
        .b_arready(m_arready[1]), .b_rid(m_rid[1]), .b_rdata(m_rdata[1]),
        .b_rresp(m_rresp[1]), .b_rlast(m_rlast[1]), .b_rvalid(m_rvalid[1]), .b_rready(m_rready[1]),
        .c_arid(m_arid[2]), .c_araddr(m_araddr[2]), .c_arlen(m_arlen[2]),
        .c_arextras(m_arextras[2]), .c_arburst(m_arburst[2]), .c_arvalid(m_arvalid[2]),
        .c_arready(m_arready[2]), .c_rid(m_rid[2]), .c_rdata(m_rdata[2]),
        .c_rresp(m_rresp[2]), .c_rlast(m_rlast[2]), .c_rvalid(m_rvalid[2]), .c_rready(m_rready[2]),
        .d_arid(m_arid[3]), .d_araddr(m_araddr[3]), .d_arlen(m_arlen[3]),
        .d_arextras(m_arextras[3]), .d_arburst(m_arburst[3]), .d_arvalid(m_arvalid[3]),
        .d_arready(m_arready[3]), .d_rid(m_rid[3]), .d_rdata(m_rdata[3]),
        .d_rresp(m_rresp[3]), .d_rlast(m_rlast[3]), .d_rvalid(m_rvalid[3]), .d_rready(m_rready[3]),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arextras(arextras), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
    );

    typedef struct packed {
        logic [IDWID+1:0]  id;
        logic [31:0]       addr;
        logic [7:0]        len;
        logic [EXTRAS-1:0] ext;
        logic [1:0]        burst;
    } ar_t;

    typedef struct packed {
        logic [IDWID-1:0] id;
        logic [DWID-1:0]  data;
        logic [1:0]       resp;
        logic             last;
    } r_t;

    typedef struct packed {
        logic [3:0] ardy;
        logic       arv;
        logic       rrdy;
        logic [3:0] rv;
    } cyc_t;

    ar_t  q_ar[$];
    r_t   q_r[4][$];
    cyc_t q_cyc[$];

    int  n_cmp  = 0;
    int  n_fail = 0;
    bit  checking = 1'b0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    function automatic logic [3:0] ardy_vec();
        return {m_arready[3], m_arready[2], m_arready[1], m_arready[0]};
    endfunction

    // Monitor: pops per-cycle expectations and expected transfers at negedge.
    always @(negedge clk) begin
        if (checking) begin
            if (q_cyc.size() == 0) begin
                chk("cyc_queue_empty", 1, 0);
            end else begin
                cyc_t e;
                e = q_cyc.pop_front();
                chk("x_arready", ardy_vec(), e.ardy);
                chk("arvalid", arvalid, e.arv);
                chk("rready", rready, e.rrdy);
                chk("x_rvalid", {m_rvalid[3], m_rvalid[2], m_rvalid[1], m_rvalid[0]}, e.rv);
            end
            if (arvalid && arready) begin
                if (q_ar.size() == 0) begin
                    chk("ar_unexpected", 1, 0);
                end else begin
                    ar_t ea;
                    ea = q_ar.pop_front();
                    chk("ar_payload", {arid, araddr, arlen, arextras, arburst}, ea);
                end
            end
            for (int x = 0; x < 4; x++) begin
                if (m_rvalid[x] && m_rready[x]) begin
                    if (q_r[x].size() == 0) begin
                        chk("r_unexpected", 1, 0);
                    end else begin
                        r_t er;
                        er = q_r[x].pop_front();
                        chk("r_beat", {m_rid[x], m_rdata[x], m_rresp[x], m_rlast[x]}, er);
                    end
                end
            end
        end
    end

    // Stimulus and reference model.
    initial begin : stim
        int occ, lg, cnt, g, stall, src, blk;
        bit load_en;
        cyc_t cy;
        ar_t  ea;
        r_t   er;

        rst = 1'b1;
        arready = 1'b0;
        rvalid = 1'b0; rid = '0; rdata = '0; rresp = '0; rlast = 1'b0;
        for (int x = 0; x < 4; x++) begin
            m_arvalid[x] = 1'b0; m_arid[x] = '0; m_araddr[x] = '0; m_arlen[x] = '0;
            m_arextras[x] = '0; m_arburst[x] = '0; m_rready[x] = 1'b1;
        end
        #12;
        chk("reset_arvalid", arvalid, 0);
        chk("reset_payload", {arid, araddr, arlen}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // First request after reset: master a, one-cycle latency to downstream.
        arready = 1'b1;
        m_arid[0] = 4'd3; m_araddr[0] = 32'h1000; m_arlen[0] = 8'd7; m_arvalid[0] = 1'b1;
        #1;
        chk("first_a_arready", ardy_vec(), 4'b0001);
        @(posedge clk); #1;
        m_arvalid[0] = 1'b0;
        chk("first_arvalid", arvalid, 1);
        chk("first_arid", arid, 6'h03);
        chk("first_araddr", araddr, 32'h1000);
        chk("first_arlen", arlen, 8'd7);
        @(posedge clk); #1;
        chk("first_drained", arvalid, 0);

        occ = 0; lg = 0; cnt = 1; g = -1; stall = 0;
        for (int n = 0; n < NCYC; n++) begin
            if (g >= 0) m_arvalid[g] = 1'b0;
            for (int x = 0; x < 4; x++) begin
                if (!m_arvalid[x] && $urandom_range(0, 99) < 45) begin
                    m_arid[x] = IDWID'($urandom);
                    m_araddr[x] = $urandom;
                    m_arlen[x] = 8'($urandom);
                    m_arextras[x] = EXTRAS'($urandom);
                    m_arburst[x] = 2'($urandom);
                    m_arvalid[x] = 1'b1;
                end
                m_rready[x] = 1'($urandom);
            end
            if (stall == 0 && $urandom_range(0, 99) < 4) stall = $urandom_range(3, 8);
            if (stall > 0) begin
                arready = 1'b0;
                stall--;
            end else begin
                arready = ($urandom_range(0, 99) < 75);
            end
            rvalid = 1'($urandom);
            rid = 6'($urandom);
            rdata = {$urandom, $urandom};
            rresp = 2'($urandom);
            rlast = ($urandom_range(0, 3) == 0);

            src = int'(rid[IDWID+1:IDWID]);
`ifdef AXI_RD_MERGER_OUTSTANDING_EN
            blk = (cnt + occ >= MAXOUT) ? 1 : 0;
`else
            blk = 0;
`endif
            load_en = (occ == 0 || arready) && blk == 0;
            g = -1;
            for (int k = 1; k <= 4; k++) begin
                int c;
                c = (lg + k) % 4;
                if (g < 0 && m_arvalid[c]) g = c;
            end
            if (!load_en) g = -1;

            cy.ardy = (g >= 0) ? 4'(1 << g) : 4'b0000;
            cy.arv  = (occ != 0);
            cy.rrdy = m_rready[src];
            cy.rv   = rvalid ? 4'(1 << src) : 4'b0000;
            q_cyc.push_back(cy);
            checking = 1'b1;

            if (rvalid && m_rready[src]) begin
                er.id = rid[IDWID-1:0]; er.data = rdata; er.resp = rresp; er.last = rlast;
                q_r[src].push_back(er);
            end

            if (occ != 0 && arready && !(rvalid && m_rready[src] && rlast)) cnt++;
            else if (!(occ != 0 && arready) && rvalid && m_rready[src] && rlast && cnt > 0) cnt--;

            if (g >= 0) begin
                ea.id = {2'(g), m_arid[g]};
                ea.addr = m_araddr[g]; ea.len = m_arlen[g];
                ea.ext = m_arextras[g]; ea.burst = m_arburst[g];
                q_ar.push_back(ea);
                lg = g;
                occ = 1;
            end else if (occ != 0 && arready) begin
                occ = 0;
            end
            @(posedge clk); #1;
        end
        checking = 1'b0;

        // Reset during a stall clears the register asynchronously.
        for (int x = 0; x < 4; x++) begin
            m_arvalid[x] = 1'b0; m_rready[x] = 1'b1;
        end
        rvalid = 1'b0;
        arready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        arready = 1'b0;
        m_arvalid[1] = 1'b1;
        #1;
        chk("stall_b_arready", ardy_vec(), 4'b0010);
        @(posedge clk); #1;
        m_arvalid[1] = 1'b0;
        m_arvalid[2] = 1'b1;
        @(posedge clk); #1;
        chk("stall_arvalid_held", arvalid, 1);
        chk("stall_c_blocked", ardy_vec(), 4'b0000);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_arvalid", arvalid, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        arready = 1'b1;
        for (int x = 0; x < 4; x++) m_arvalid[x] = 1'b1;
        #1;
        chk("post_reset_a_first", ardy_vec(), 4'b0001);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
